// File: rtl/uart_pkg.sv
// Purpose: shared UART receiver constants, FSM state encoding and sizing helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

  // Parity mode selectors for the PARITY_MODE parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Receiver frame state
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Width of a counter holding 0 .. nb_ovs-1
  function automatic int ovs_cnt_w(input int nb_ovs);
    return (nb_ovs <= 2) ? 1 : $clog2(nb_ovs);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose: 2-flop synchroniser for the asynchronous serial line, resets to idle (1).
// Latency: 2 i_clk cycles from i_rx to o_rx_s.
// Backpressure: none; free-running every cycle.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_rx_s
);

  logic meta;

  // Two-stage capture; reset value 1 so a reset never looks like a start bit
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta   <= 1'b1;
      o_rx_s <= 1'b1;
    end else begin
      meta   <= i_rx;
      o_rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Purpose: parametrised UART receiver with majority-vote sampling and start glitch rejection.
// Latency: o_rx_done one cycle after the mid-bit tick of the last stop bit (plus 2-cycle line sync).
// Backpressure: none; o_rx_done is a single-cycle pulse the consumer must take when it fires.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int NB_BITS     = 8,
  parameter int NB_OVS      = 16,
  parameter int PARITY_MODE = 0,
  parameter int NB_STOP     = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rate,
  input  logic               i_rx,
  output logic [NB_BITS-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int CW = ovs_cnt_w(NB_OVS);

  // Sample points around the bit centre; the vote resolves on the last one
  localparam logic [CW-1:0] T_S0  = CW'(NB_OVS/2 - 1);
  localparam logic [CW-1:0] T_S1  = CW'(NB_OVS/2);
  localparam logic [CW-1:0] T_S2  = CW'(NB_OVS/2 + 1);
  localparam logic [CW-1:0] T_END = CW'(NB_OVS - 1);

  localparam logic [3:0] LAST_DATA = 4'(NB_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(NB_STOP - 1);

  rx_state_t          state, state_nxt;
  logic [CW-1:0]      tick_cnt, tick_nxt;
  logic [3:0]         bit_cnt, bit_nxt;
  logic               rx_s;
  logic               smp0, smp1;
  logic               vote;
  logic               at_vote, at_end;
  logic               start_en, shift_en, par_en, stop_en, done_en;
  logic [NB_BITS-1:0] shreg;
  logic               par_bit;
  logic               frame_acc;
  logic               par_sum;
  logic               par_err;

  uart_rx_sync u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rx   (i_rx),
    .o_rx_s (rx_s)
  );

  assign at_vote = i_rate && (tick_cnt == T_S2);
  assign at_end  = i_rate && (tick_cnt == T_END);

  // 2-of-3 vote: two stored samples plus the live one at the third sample tick
  assign vote = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);

  // Parity check over the assembled word and the received parity bit
  assign par_sum = (^shreg) ^ par_bit;
  assign par_err = (PARITY_MODE == PAR_EVEN) ? par_sum :
                   (PARITY_MODE == PAR_ODD)  ? ~par_sum : 1'b0;

  assign o_busy = (state != ST_IDLE);

  // FSM state and bit/tick counters
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
    end
  end

  // Next-state logic and datapath strobes
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    start_en  = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    done_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        tick_nxt = '0;
        bit_nxt  = '0;
        // Start edge is looked for every clock, not only on ticks
        if (!rx_s) begin
          state_nxt = ST_START;
          start_en  = 1'b1;
        end
      end
      ST_START: begin
        if (i_rate) tick_nxt = tick_cnt + 1'b1;
        if (at_vote && vote) begin
          // Line went back high before mid-bit: treat as a glitch
          state_nxt = ST_IDLE;
          tick_nxt  = '0;
        end else if (at_end) begin
          state_nxt = ST_DATA;
          tick_nxt  = '0;
          bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (i_rate) tick_nxt = tick_cnt + 1'b1;
        if (at_vote) shift_en = 1'b1;
        if (at_end) begin
          tick_nxt = '0;
          if (bit_cnt == LAST_DATA) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (i_rate) tick_nxt = tick_cnt + 1'b1;
        if (at_vote) par_en = 1'b1;
        if (at_end) begin
          tick_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (i_rate) tick_nxt = tick_cnt + 1'b1;
        if (at_vote) begin
          if (bit_cnt == LAST_STOP) begin
            // Finish mid-way through the last stop bit to leave resync margin
            done_en   = 1'b1;
            state_nxt = ST_IDLE;
            tick_nxt  = '0;
            bit_nxt   = '0;
          end else begin
            stop_en = 1'b1;
          end
        end else if (at_end) begin
          tick_nxt = '0;
          bit_nxt  = bit_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tick_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Capture the first two of the three centre samples of each bit
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      smp0 <= 1'b0;
      smp1 <= 1'b0;
    end else if (i_rate && (state != ST_IDLE)) begin
      if (tick_cnt == T_S0) smp0 <= rx_s;
      if (tick_cnt == T_S1) smp1 <= rx_s;
    end
  end

  // Frame accumulation: LSB-first shift, parity bit, early stop-bit errors
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      shreg     <= '0;
      par_bit   <= 1'b0;
      frame_acc <= 1'b0;
    end else begin
      if (start_en) begin
        par_bit   <= 1'b0;
        frame_acc <= 1'b0;
      end
      if (shift_en) shreg <= {vote, shreg[NB_BITS-1:1]};
      if (par_en) par_bit <= vote;
      if (stop_en && !vote) frame_acc <= 1'b1;
    end
  end

  // Registered outputs; word and flags hold until the next completed frame
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_data       <= '0;
      o_rx_done    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_rx_done <= done_en;
      if (done_en) begin
        o_data       <= shreg;
        o_parity_err <= par_err;
        o_frame_err  <= frame_acc | ~vote;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Purpose: directed self-checking bench for uart_rx_param (8N1, 8E1 and 8N2 instances).
// Latency: frames driven at 4 clocks per tick, 16 ticks per bit.
// Backpressure: none; done pulses are logged by a monitor on the falling edge.
module tb_uart_rx_param;

  logic       clk;
  logic       rst_n;
  logic       rate;
  logic [2:0] rx;
  logic [7:0] data [3];
  logic [2:0] done, perr, ferr, busy;

  int         n_tests;
  int         n_fail;
  int         dcnt  [3];
  logic [7:0] ldat  [3];
  logic       lperr [3];
  logic       lferr [3];

  // Instance 0: 8N1, instance 1: 8E1, instance 2: 8N2
  uart_rx_param #(.NB_BITS(8), .NB_OVS(16), .PARITY_MODE(0), .NB_STOP(1)) u_a (
    .i_clk(clk), .i_rst(rst_n), .i_rate(rate), .i_rx(rx[0]),
    .o_data(data[0]), .o_rx_done(done[0]), .o_parity_err(perr[0]),
    .o_frame_err(ferr[0]), .o_busy(busy[0]));

  uart_rx_param #(.NB_BITS(8), .NB_OVS(16), .PARITY_MODE(1), .NB_STOP(1)) u_b (
    .i_clk(clk), .i_rst(rst_n), .i_rate(rate), .i_rx(rx[1]),
    .o_data(data[1]), .o_rx_done(done[1]), .o_parity_err(perr[1]),
    .o_frame_err(ferr[1]), .o_busy(busy[1]));

  uart_rx_param #(.NB_BITS(8), .NB_OVS(16), .PARITY_MODE(0), .NB_STOP(2)) u_c (
    .i_clk(clk), .i_rst(rst_n), .i_rate(rate), .i_rx(rx[2]),
    .o_data(data[2]), .o_rx_done(done[2]), .o_parity_err(perr[2]),
    .o_frame_err(ferr[2]), .o_busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oversampling tick: one cycle high out of every four
  initial begin
    rate = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      rate = 1'b1;
      @(negedge clk);
      rate = 1'b0;
    end
  end

  // Log every done pulse with the word and flags seen alongside it
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) begin
        dcnt[i]  = dcnt[i] + 1;
        ldat[i]  = data[i];
        lperr[i] = perr[i];
        lferr[i] = ferr[i];
      end
    end
  end

  // Hard stop if something wedges the run
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Returns 1 ns after the n-th clock edge on which the tick was high
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      while (!rate) @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; spike_bit >= 0 puts a one-tick low pulse at that data bit's centre
  task automatic send_frame(input int inst, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic s1, input logic s2,
                            input bit two_stop, input int spike_bit);
    rx[inst] = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx[inst] = d[i];
      if (i == spike_bit) begin
        wait_ticks(8);
        rx[inst] = 1'b0;
        wait_ticks(1);
        rx[inst] = d[i];
        wait_ticks(7);
      end else begin
        wait_ticks(16);
      end
    end
    if (use_par) begin
      rx[inst] = pbit;
      wait_ticks(16);
    end
    rx[inst] = s1;
    wait_ticks(16);
    if (two_stop) begin
      rx[inst] = s2;
      wait_ticks(16);
    end
    rx[inst] = 1'b1;
  endtask

  typedef struct {
    int         inst;
    logic [7:0] d;
    bit         use_par;
    logic       pbit;
    logic       s1;
    logic       s2;
    bit         two;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t       vt [9];
  int         base;
  logic [7:0] last_a;

  initial begin
    // inst, data, par?, pbit, stop1, stop2, 2stop?, exp data, exp perr, exp ferr
    vt[0] = '{0, 8'h51, 0, 1'b0, 1'b1, 1'b1, 0, 8'h51, 1'b0, 1'b0};
    vt[1] = '{1, 8'hA5, 1, 1'b1, 1'b1, 1'b1, 0, 8'hA5, 1'b1, 1'b0};
    vt[2] = '{1, 8'hA5, 1, 1'b0, 1'b1, 1'b1, 0, 8'hA5, 1'b0, 1'b0};
    vt[3] = '{2, 8'h3C, 0, 1'b0, 1'b1, 1'b0, 1, 8'h3C, 1'b0, 1'b1};
    vt[4] = '{0, 8'h96, 0, 1'b0, 1'b0, 1'b1, 0, 8'h96, 1'b0, 1'b1};
    vt[5] = '{2, 8'hC3, 0, 1'b0, 1'b1, 1'b1, 1, 8'hC3, 1'b0, 1'b0};
    vt[6] = '{1, 8'h01, 1, 1'b1, 1'b1, 1'b1, 0, 8'h01, 1'b0, 1'b0};
    vt[7] = '{1, 8'h80, 1, 1'b0, 1'b1, 1'b1, 0, 8'h80, 1'b1, 1'b0};
    vt[8] = '{2, 8'h3C, 0, 1'b0, 1'b0, 1'b1, 1, 8'h3C, 1'b0, 1'b1};

    n_tests = 0;
    n_fail  = 0;
    last_a  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      dcnt[i]  = 0;
      ldat[i]  = 8'h00;
      lperr[i] = 1'b0;
      lferr[i] = 1'b0;
    end
    rx    = 3'b111;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", {24'h0, data[0]}, 32'h0);
    chk("rst_done", {29'h0, done}, 32'h0);
    chk("rst_perr", {29'h0, perr}, 32'h0);
    chk("rst_ferr", {29'h0, ferr}, 32'h0);
    chk("rst_busy", {29'h0, busy}, 32'h0);
    rst_n = 1'b1;
    wait_ticks(4);

    // Table-driven frames, each followed by an idle gap
    for (int v = 0; v < 9; v++) begin
      base = dcnt[vt[v].inst];
      send_frame(vt[v].inst, vt[v].d, vt[v].use_par, vt[v].pbit,
                 vt[v].s1, vt[v].s2, vt[v].two, -1);
      wait_ticks(24);
      chk($sformatf("v%0d_done_cnt", v), 32'(dcnt[vt[v].inst] - base), 32'd1);
      chk($sformatf("v%0d_data", v), {24'h0, ldat[vt[v].inst]}, {24'h0, vt[v].exp_d});
      chk($sformatf("v%0d_perr", v), {31'h0, lperr[vt[v].inst]}, {31'h0, vt[v].exp_pe});
      chk($sformatf("v%0d_ferr", v), {31'h0, lferr[vt[v].inst]}, {31'h0, vt[v].exp_fe});
      chk($sformatf("v%0d_busy_idle", v), {31'h0, busy[vt[v].inst]}, 32'h0);
      if (vt[v].inst == 0) last_a = vt[v].exp_d;
    end

    // Start glitch: 3 ticks low, then back high
    base = dcnt[0];
    rx[0] = 1'b0;
    wait_ticks(3);
    chk("glitch_busy_hi", {31'h0, busy[0]}, 32'h1);
    rx[0] = 1'b1;
    wait_ticks(16);
    chk("glitch_busy_lo", {31'h0, busy[0]}, 32'h0);
    chk("glitch_no_done", 32'(dcnt[0] - base), 32'd0);
    chk("glitch_data_held", {24'h0, data[0]}, {24'h0, last_a});

    // One-tick spike at the centre sample of data bit 3 of 0xFF
    base = dcnt[0];
    send_frame(0, 8'hFF, 0, 1'b0, 1'b1, 1'b1, 0, 3);
    wait_ticks(24);
    chk("spike_done_cnt", 32'(dcnt[0] - base), 32'd1);
    chk("spike_data", {24'h0, ldat[0]}, 32'hFF);

    // Back-to-back frames with no idle gap
    base = dcnt[0];
    send_frame(0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 0, -1);
    chk("b2b0_done_cnt", 32'(dcnt[0] - base), 32'd1);
    chk("b2b0_data", {24'h0, ldat[0]}, 32'h00);
    send_frame(0, 8'hFF, 0, 1'b0, 1'b1, 1'b1, 0, -1);
    chk("b2b1_done_cnt", 32'(dcnt[0] - base), 32'd2);
    chk("b2b1_data", {24'h0, ldat[0]}, 32'hFF);
    chk("b2b1_ferr", {31'h0, lferr[0]}, 32'h0);

    // Third frame cut short by reset
    rx[0] = 1'b0;
    wait_ticks(16);
    rx[0] = 1'b1;
    wait_ticks(16);
    rx[0] = 1'b0;
    wait_ticks(16);
    rx[0] = 1'b1;
    wait_ticks(5);
    chk("mid_busy", {31'h0, busy[0]}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_data", {24'h0, data[0]}, 32'h0);
    chk("mrst_done", {31'h0, done[0]}, 32'h0);
    chk("mrst_busy", {31'h0, busy[0]}, 32'h0);
    chk("mrst_ferr", {31'h0, ferr[0]}, 32'h0);
    repeat (5) @(posedge clk);
    rx = 3'b111;
    #1;
    rst_n = 1'b1;
    wait_ticks(40);
    chk("mrst_no_third", 32'(dcnt[0] - base), 32'd2);
    chk("mrst_idle", {31'h0, busy[0]}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
